// File: rtl/pcpu_pkg.sv
// Shared types and constants for the pipelined CPU memory/IO arbiter.
package pcpu_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'b00,
    ARB_BUSY_D = 2'b01,
    ARB_BUSY_I = 2'b10
  } arb_state_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int ARB_WAIT_STATES = 1;

  // Wait counter width; never narrower than one bit.
  function automatic int cnt_width(input int ws);
    return (ws < 2) ? 1 : $clog2(ws + 1);
  endfunction

endpackage

// File: rtl/arb_wait_cnt.sv
// Loadable down-counter that stops at zero and flags it.
module arb_wait_cnt #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                cnt <= '0;
    else if (load)             cnt <= load_val;
    else if (dec && cnt != '0) cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pcpu_mem_arbiter.sv
// Shares one memory/IO bus between fetch and data ports with wait states
// and MIO_ready handshake; stalls the pipeline while a request is open.
module pcpu_mem_arbiter
  import pcpu_pkg::*;
#(
  parameter int WAIT_STATES = ARB_WAIT_STATES,
  parameter int AW          = 32,
  parameter int DW          = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          stall,
  output logic          mem_en,
  output logic          mem_w,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          MIO_ready
);

  localparam int CW = cnt_width(WAIT_STATES);

  arb_state_e state, state_nxt;
  logic       last_d, req_i, req_d, gnt_i, gnt_d, gnt_port, busy, zero, done;

  // A port is masked in its own ack cycle: the requester still holds req.
  assign req_i = if_req & ~if_ack;
  assign req_d = d_req & ~d_ack;
  assign stall = req_i | req_d;
  assign done  = busy & zero & MIO_ready;

  arb_wait_cnt #(.W(CW)) u_wait_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (gnt_i | gnt_d),
    .dec      (busy),
    .load_val (CW'(WAIT_STATES)),
    .zero     (zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ARB_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: begin
        if (gnt_d)      state_nxt = ARB_BUSY_D;
        else if (gnt_i) state_nxt = ARB_BUSY_I;
      end
      ARB_BUSY_D, ARB_BUSY_I: if (done) state_nxt = ARB_IDLE;
      default:                state_nxt = ARB_IDLE;
    endcase
  end

  // Data wins a tie unless it won the previous grant.
  always_comb begin
    gnt_d    = 1'b0;
    gnt_i    = 1'b0;
    gnt_port = PORT_I;
    busy     = 1'b0;
    if (state == ARB_IDLE) begin
      gnt_d    = req_d & (~req_i | ~last_d);
      gnt_i    = req_i & ~gnt_d;
      gnt_port = gnt_d ? PORT_D : PORT_I;
    end else begin
      busy     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_en    <= 1'b0;
      mem_w     <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      last_d    <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      if (gnt_i | gnt_d) begin
        mem_en   <= 1'b1;
        mem_w    <= gnt_d & d_we;
        mem_addr <= gnt_d ? d_addr : if_addr;
        if (gnt_d) mem_wdata <= d_wdata;
        last_d   <= (gnt_port == PORT_D);
      end else if (done) begin
        mem_en <= 1'b0;
        mem_w  <= 1'b0;
        if (state == ARB_BUSY_I) begin
          if_rdata <= mem_rdata;
          if_ack   <= 1'b1;
        end else begin
          if (!mem_w) d_rdata <= mem_rdata;
          d_ack <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pcpu_mem_arbiter.sv
// Directed bench for pcpu_mem_arbiter; acks are checked by a scoreboard monitor.
module tb_pcpu_mem_arbiter;

  localparam int WS = 1;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0, reset = 1'b0;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, MIO_ready = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ack, d_ack, stall, mem_en, mem_w;

  int   cyc = 0, n_chk = 0, n_fail = 0;
  exp_t qi[$], qd[$];

  pcpu_mem_arbiter #(.WAIT_STATES(WS), .AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .stall(stall),
    .mem_en(mem_en), .mem_w(mem_w), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .MIO_ready(MIO_ready)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input string nm, input logic en, input logic w, input logic [31:0] addr);
    @(negedge clk);
    chk({nm, " mem_en"}, 32'(mem_en), 32'(en));
    chk({nm, " mem_w"},  32'(mem_w),  32'(w));
    if (en) chk({nm, " mem_addr"}, mem_addr, addr);
  endtask

  // Scoreboard monitor: every ack must match the oldest expectation for its port.
  always @(negedge clk) begin
    exp_t e;
    if (if_ack) begin
      if (qi.size() == 0) chk("unexpected if_ack", 32'(if_ack), 32'd0);
      else begin
        e = qi.pop_front();
        chk("if_rdata", if_rdata, e.data);
        chk("if_ack cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (d_ack) begin
      if (qd.size() == 0) chk("unexpected d_ack", 32'(d_ack), 32'd0);
      else begin
        e = qd.pop_front();
        chk("d_rdata", d_rdata, e.data);
        chk("d_ack cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    int c;
    // Reset, then idle with no requests
    tick(); tick(); reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      @(negedge clk);
      chk("idle ctl", 32'({mem_en, mem_w, if_ack, d_ack, stall}), 32'd0);
      chk("idle bus", mem_addr | mem_wdata | if_rdata | d_rdata, 32'd0);
    end

    // Fetch only
    tick(); c = cyc;
    if_req = 1'b1; if_addr = 32'h0000_0040; mem_rdata = 32'h2008_0005; MIO_ready = 1'b1;
    qi.push_back('{32'h2008_0005, c + WS + 2});
    @(negedge clk);
    chk("fetch req stall", 32'(stall), 32'd1);
    chk("fetch req mem_en", 32'(mem_en), 32'd0);
    for (int k = 1; k <= WS + 1; k++) begin
      tick(); bus("fetch busy", 1'b1, 1'b0, 32'h0000_0040);
    end
    tick(); @(negedge clk);
    chk("fetch ack mem_en", 32'(mem_en), 32'd0);
    chk("fetch ack stall", 32'(stall), 32'd0);
    tick(); if_req = 1'b0;
    @(negedge clk);
    chk("if_rdata held", if_rdata, 32'h2008_0005);

    // Dual request after reset: store first, then fetch
    tick(); reset = 1'b0; tick(); tick(); reset = 1'b1;
    tick(); c = cyc;
    if_req = 1'b1; if_addr = 32'h0000_0080; mem_rdata = 32'h1111_2222;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0100; d_wdata = 32'hDEAD_BEEF;
    qd.push_back('{32'h0, c + 3});
    qi.push_back('{32'h1111_2222, c + 6});
    tick(); bus("dual store", 1'b1, 1'b1, 32'h0000_0100);
    chk("dual store wdata", mem_wdata, 32'hDEAD_BEEF);
    tick(); bus("dual store hold", 1'b1, 1'b1, 32'h0000_0100);
    tick(); bus("dual d_ack cycle", 1'b0, 1'b0, 32'h0);
    tick(); d_req = 1'b0;
    bus("dual fetch", 1'b1, 1'b0, 32'h0000_0080);
    tick(); tick(); tick(); if_req = 1'b0;

    // Lone store sets last_d; the next dual request must go to fetch first
    c = cyc;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0104; d_wdata = 32'hCAFE_F00D;
    qd.push_back('{32'h0, c + 3});
    tick(); tick(); tick(); tick();
    if_req = 1'b1; if_addr = 32'h0000_00C0;
    d_we = 1'b0; d_addr = 32'h0000_0200; mem_rdata = 32'h3333_4444;
    qi.push_back('{32'h3333_4444, c + 7});
    qd.push_back('{32'h5555_6666, c + 10});
    tick(); bus("anti-starve fetch", 1'b1, 1'b0, 32'h0000_00C0);
    tick(); tick(); mem_rdata = 32'h5555_6666;
    bus("anti-starve if_ack cycle", 1'b0, 1'b0, 32'h0);
    tick(); if_req = 1'b0;
    bus("anti-starve load", 1'b1, 1'b0, 32'h0000_0200);
    tick(); tick(); tick(); d_req = 1'b0;

    // Load with MIO_ready low for 4 cycles at cnt==0
    c = cyc;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300; MIO_ready = 1'b0; mem_rdata = 32'h7777_8888;
    qd.push_back('{32'h7777_8888, c + 7});
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 6) MIO_ready = 1'b1;
      bus("wait load", 1'b1, 1'b0, 32'h0000_0300);
      chk("wait stall", 32'(stall), 32'd1);
    end
    tick(); @(negedge clk);
    chk("wait ack stall", 32'(stall), 32'd0);
    chk("wait ack mem_en", 32'(mem_en), 32'd0);
    tick(); d_req = 1'b0;

    // Async reset during a store, then re-grant of the held request
    tick();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0400; d_wdata = 32'h1234_5678;
    tick(); bus("pre-reset store", 1'b1, 1'b1, 32'h0000_0400);
    #2 reset = 1'b0;
    #1;
    chk("async reset mem_en", 32'(mem_en), 32'd0);
    chk("async reset mem_w", 32'(mem_w), 32'd0);
    tick(); tick(); reset = 1'b1; c = cyc;
    qd.push_back('{32'h0, c + 3});
    tick(); bus("re-grant store", 1'b1, 1'b1, 32'h0000_0400);
    tick(); tick(); tick(); d_req = 1'b0;

    tick(); tick(); tick();
    chk("scoreboard drained", 32'(qi.size() + qd.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pcpu_mem_arbiter.md
# pcpu_mem_arbiter

Single-port memory/IO arbiter for the pipelined CPU. It shares one memory/IO bus between the instruction-fetch port and the data port (load/store), and handles multi-cycle memory with a programmable wait-state count plus the `MIO_ready` handshake. It sits between the `mips` core and the memory/IO subsystem, and drives the pipeline stall while a request is outstanding.

## Interface
Parameters:
- `WAIT_STATES`, 1, extra bus cycles per access before `MIO_ready` is sampled (0..15).
- `AW`, 32, address width.
- `DW`, 32, data width.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch request; held until `if_ack`.
- `if_addr`  in  AW  fetch address.
- `if_rdata`  out  DW  fetched instruction; valid in the `if_ack` cycle and held until the next fetch ack.
- `if_ack`  out  1  one-cycle fetch completion pulse.
- `d_req`  in  1  data request; held until `d_ack`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  AW  data address.
- `d_wdata`  in  DW  store data.
- `d_rdata`  out  DW  load data; valid in the `d_ack` cycle and held until the next data ack.
- `d_ack`  out  1  one-cycle data completion pulse.
- `stall`  out  1  `(if_req & ~if_ack) | (d_req & ~d_ack)`; combinational.
- `mem_en`  out  1  bus access active.
- `mem_w`  out  1  bus write enable.
- `mem_addr`  out  AW  bus address.
- `mem_wdata`  out  DW  bus write data.
- `mem_rdata`  in  DW  bus read data.
- `MIO_ready`  in  1  memory/IO ready; the access completes when high after the wait states.

## Operation
- FSM states: `IDLE`, `BUSY_D`, `BUSY_I`.
- **IDLE**
  - Arbitrate among the unmasked pending requests.
  - A single requester is granted.
  - If both are pending, data wins unless `last_d`=1, in which case fetch wins (anti-starvation).
  - On grant: latch address, wdata and we into bus registers; load `cnt` ← `WAIT_STATES`; set `last_d` ← (grant==data).
- **BUSY_x**
  - `mem_en`=1. `mem_w`=latched `we` (data only; always 0 for fetch).
  - While `cnt`≠0: decrement.
  - When `cnt`==0 and `MIO_ready`=1: capture `mem_rdata` into `x_rdata` (loads/fetches only; stores leave `d_rdata` unchanged). Pulse `x_ack` next cycle and return to IDLE.
  - `MIO_ready`=0 at `cnt`==0: hold state, bus and counter unchanged, indefinitely.
- **Ack-cycle mask:** in the `x_ack` cycle the arbiter is in IDLE but ignores `x_req`, because the requester is still holding it. The other port may be granted in that cycle.
- Requester inputs changing during BUSY are ignored; the bus values come from the latched registers.
- **Reset (any time, including mid-access):**
  - State IDLE.
  - `mem_en`, `mem_w`, `if_ack`, `d_ack` = 0.
  - `mem_addr`, `mem_wdata`, `if_rdata`, `d_rdata` = 0.
  - `cnt`, `last_d` = 0.
  - An in-flight access is abandoned with no ack.
- `cnt` width: `max(1, $clog2(WAIT_STATES+1))`.

## Timing
- All outputs are registered except `stall`.
- **Request-to-ack latency** with `MIO_ready` held high: `WAIT_STATES`+2 cycles.
  - Cycle 0: request sampled in IDLE.
  - Cycles 1..`WAIT_STATES`+1: BUSY.
  - Cycle `WAIT_STATES`+2: ack.
- Each cycle `MIO_ready` is low at `cnt`==0 adds one cycle.
- **Back-to-back, same port:** the next request is granted no earlier than one cycle after the ack, so throughput is one access per `WAIT_STATES`+3 cycles.
- **Alternating ports:** one access per `WAIT_STATES`+2 cycles.
- `mem_*` outputs are stable for the whole BUSY interval.

## Structure
- Shared package `pcpu_pkg`:
  - State encoding `ARB_IDLE`=2'b00, `ARB_BUSY_D`=2'b01, `ARB_BUSY_I`=2'b10.
  - Port ID constants `PORT_I`=0, `PORT_D`=1.
  - Default `WAIT_STATES`.
- One natural sub-module, `arb_wait_cnt`: loadable down-counter with a `zero` flag. The FSM, grant logic and bus registers stay in the top.

## Test plan
- Reset released with no requests, `WAIT_STATES`=1 → all outputs 0 and `stall`=0 for 10 cycles.
- Fetch only: `if_addr`=0x0000_0040, `mem_rdata`=0x2008_0005, `MIO_ready`=1 → `mem_en` high in cycles 1-2, `if_ack` in cycle 3 with `if_rdata`=0x2008_0005, `mem_w`=0 throughout.
- Simultaneous `if_req` and store (`d_addr`=0x0000_0100, `d_wdata`=0xDEAD_BEEF) after reset → data granted first (`mem_w`=1, `d_ack` in cycle 3), fetch granted in cycle 3 and acked in cycle 6; a repeated dual request then goes to fetch first, since `last_d`=1.
- Load with `MIO_ready` held low for 4 cycles at `cnt`==0 → `d_ack` delayed exactly 4 cycles; `mem_addr` stable throughout; `stall` high until the ack cycle.
- Async reset asserted mid-BUSY_D → `mem_en`/`mem_w` drop immediately with no `d_ack`; after release, the held `d_req` is re-granted and completes normally.
